expr_emitter: RTL
=================

// Module: expr_emitter
// PURPOSE
//  Transmit side of the single-digit expression character stream: serializes a
//  packed expression (operands 0..9, operators '+'/'*') into ASCII bytes, one per
//  accepted transfer, in the form D op D op ... D. Its output feeds the
//  expression-string checker directly, so every emitted stream is well-formed.
// PARAMETERS
//  MAX_OPS  4  max operand count per expression, legal range 2..7
// PORTS
//  clk        in   1            rising-edge clock
//  clr_n      in   1            synchronous reset, active-low
//  start      in   1            request: latch operands/operators, begin emission
//  num_ops    in   3            operand count for this request, 1..MAX_OPS
//  operands   in   4*MAX_OPS    operand i at [4i+3:4i], binary 0..9
//  operators  in   MAX_OPS-1    op i between operand i and i+1: 0='+', 1='*'
//  busy       out  1            emission in progress; start ignored
//  out_valid  out  1            out_char holds a valid byte
//  out_ready  in   1            sink accepts byte when out_valid&&out_ready
//  out_char   out  8            ASCII byte: '0'..'9' (48..57), '+' (43), '*' (42)
//  out_last   out  1            marks final byte of expression (qualified by valid)
//  done       out  1            1-cycle pulse after final byte accepted
//  err        out  1            1-cycle pulse: rejected request
// BEHAVIOUR
//  - Clock/reset: single clock; clr_n sampled only on rising clk edge; no async path.
//  - Reset values: busy=0, out_valid=0, out_char=8'h00, out_last=0, done=0, err=0;
//    FSM=IDLE, index=0.
//  - FSM states: IDLE, DIG, OP.
//    IDLE: start=1 with legal request -> latch all inputs, index=0, -> DIG.
//      Illegal (num_ops==0, num_ops>MAX_OPS, or any used operand >9; unused
//      operand slots not checked) -> err=1 next cycle, stay IDLE, nothing latched.
//    DIG: out_char=48+operand[index]; out_last=(index==num_ops-1).
//      On transfer: if last -> IDLE, done=1 next cycle; else -> OP.
//    OP: out_char=operators[index]?42:43, out_last=0. On transfer: index++, -> DIG.
//  - Latency: start sampled at edge k -> first byte valid from cycle k+1
//    (out_valid registered). Back-to-back transfers: 1 byte/cycle while out_ready=1.
//  - Handshake: once out_valid=1, out_char/out_last hold stable until transfer;
//    out_valid never drops without a transfer (except reset).
//  - Stream length = 2*num_ops-1 bytes; num_ops=1 emits a single digit with out_last=1.
//  - busy=1 from cycle after accepted start through cycle of final transfer;
//    start while busy ignored, no err. start in same cycle as done pulse accepted
//    (FSM already IDLE).
//  - Latched copies used throughout; input changes during emission have no effect.
//  - Reset mid-operation: clr_n=0 at any edge -> reset values next cycle, partial
//    stream abandoned, no done/err pulse.
//  - done and err never asserted together; each exactly 1 cycle.
// TESTING
//  1. num_ops=3, operands={..,7,2,5} (op0=5), operators=2'b10, out_ready=1 ->
//     bytes 53,43,50,42,55 on 5 consecutive cycles; out_last only on 55; done next cycle.
//  2. Same as 1 with out_ready toggling 0/1 each cycle -> same 5 bytes, each held
//     stable while stalled, total 10 cycles of out_valid.
//  3. num_ops=1, operand0=0 -> single byte 48 with out_last=1, then done pulse.
//  4. num_ops=2, operand1=10 -> err=1 one cycle, out_valid stays 0, busy stays 0;
//     num_ops=0 -> err; num_ops=5 (MAX_OPS=4) -> err.
//  5. start during emission with different operands -> ignored, original stream
//     completes unchanged.
//  6. clr_n=0 after 2nd byte of case 1 -> next cycle out_valid=0, busy=0; new start
//     restarts at first digit (53).

Source files
------------

// File: rtl/expr_emitter.sv
// rtl/expr_emitter.sv - serializes a packed single-digit expression into an ASCII byte stream
module expr_emitter #(
  parameter int MAX_OPS = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [2:0]             num_ops,
  input  logic [4*MAX_OPS-1:0]   operands,
  input  logic [MAX_OPS-2:0]     operators,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_char,
  output logic                   out_last,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, DIG, OP} state_t;

  localparam logic [2:0] MAX_N = 3'(MAX_OPS);

  state_t                 state, state_nx;
  logic [2:0]             idx, idx_nx;
  logic [2:0]             n_q;
  logic [4*MAX_OPS-1:0]   ops_q;
  logic [MAX_OPS-2:0]     opr_q;
  logic                   done_q, err_q;
  logic                   done_nx, err_nx;
  logic                   load;
  logic                   legal;
  logic [3:0]             cur_dig;
  logic                   cur_op;
  logic                   is_last;
  logic                   xfer;

  // Request legality: count in range and every used operand a decimal digit.
  always_comb begin
    legal = (num_ops != 3'd0) && (num_ops <= MAX_N);
    for (int i = 0; i < MAX_OPS; i++) begin
      if ((3'(i) < num_ops) && (operands[4*i +: 4] > 4'd9)) begin
        legal = 1'b0;
      end
    end
  end

  // Select the latched operand and operator addressed by the current index.
  always_comb begin
    cur_dig = 4'd0;
    cur_op  = 1'b0;
    for (int i = 0; i < MAX_OPS; i++) begin
      if (idx == 3'(i)) begin
        cur_dig = ops_q[4*i +: 4];
      end
    end
    for (int i = 0; i < MAX_OPS - 1; i++) begin
      if (idx == 3'(i)) begin
        cur_op = opr_q[i];
      end
    end
  end

  assign is_last = (idx == (n_q - 3'd1));
  assign xfer    = out_valid && out_ready;

  // Next-state logic and pulse generation.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal) begin
            load     = 1'b1;
            idx_nx   = 3'd0;
            state_nx = DIG;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      DIG: begin
        if (xfer) begin
          if (is_last) begin
            state_nx = IDLE;
            idx_nx   = 3'd0;
            done_nx  = 1'b1;
          end else begin
            state_nx = OP;
          end
        end
      end
      OP: begin
        if (xfer) begin
          idx_nx   = idx + 3'd1;
          state_nx = DIG;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // Output decode; the byte is a pure function of registered state so it holds while stalled.
  always_comb begin
    out_valid = (state != IDLE);
    busy      = (state != IDLE);
    out_last  = (state == DIG) && is_last;
    out_char  = 8'h00;
    if (state == DIG) begin
      out_char = 8'd48 + {4'd0, cur_dig};
    end else if (state == OP) begin
      out_char = cur_op ? 8'd42 : 8'd43;
    end
  end

  assign done = done_q;
  assign err  = err_q;

  // State, index, latched request and pulse registers.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state  <= IDLE;
      idx    <= 3'd0;
      n_q    <= 3'd0;
      ops_q  <= '0;
      opr_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      if (load) begin
        n_q   <= num_ops;
        ops_q <= operands;
        opr_q <= operators;
      end
    end
  end

endmodule
